reset_sequencer: RTL and testbench

//  Generates per-pipeline-stage active-low clears for the MIPS core's flops, which clear on clearb.

---
 rtl/reset_seq_pkg.sv | 23 ++
 rtl/reset_sync.sv | 19 +
 rtl/reset_sequencer.sv | 165 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding, parameter minimums
// and a counter-width helper. Also imported by the bench for state checks.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } reset_state_e;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MIN_HOLD_CYCLES = 1;
  localparam int MIN_NUM_DOMAINS = 1;
  localparam int MIN_STAGGER     = 1;
  localparam int MIN_WDOG_CYCLES = 2;

  // Width of a counter that must hold 0..limit-1, never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-deassert reset synchroniser, SYNC_STAGES flops deep.
module reset_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic clearb,
  output logic sync_n
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clock or negedge clearb) begin
    if (!clearb) chain_q <= '0;
    else         chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_n = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Per-stage reset sequencer: hold all clears, then release WB..IF one every STAGGER cycles.
// Optional watchdog re-run enabled by defining RESET_WDOG_EN.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_DOMAINS = 5,
  parameter int STAGGER     = 4,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   clearb,
  input  logic                   soft_rst_req,
  output logic [NUM_DOMAINS-1:0] stage_clearb,
  output logic                   rst_done,
  output logic                   busy,
`ifdef RESET_WDOG_EN
  input  logic                   wdog_kick,
  output logic                   wdog_fired,
`endif
  output reset_state_e           fsm_state
);

  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam int SW = cnt_width(STAGGER);
  localparam int IW = cnt_width(NUM_DOMAINS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER - 1);
  localparam logic [IW-1:0] IDX_FIRST = IW'(NUM_DOMAINS - 2);

  if (SYNC_STAGES < MIN_SYNC_STAGES || HOLD_CYCLES < MIN_HOLD_CYCLES ||
      NUM_DOMAINS < MIN_NUM_DOMAINS || STAGGER < MIN_STAGGER ||
      WDOG_CYCLES < MIN_WDOG_CYCLES) begin : g_bad_params
    $error("reset_sequencer: parameter below legal minimum");
  end

  logic sync_n;

  reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock  (clock),
    .clearb (clearb),
    .sync_n (sync_n)
  );

  reset_state_e           state_q, state_d;
  logic [HW-1:0]          hcnt_q, hcnt_d;
  logic [SW-1:0]          scnt_q, scnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] stage_q, stage_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   restart;
  logic                   wdog_expire;

`ifdef RESET_WDOG_EN
  localparam int WW = cnt_width(WDOG_CYCLES);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          fired_q, fired_d;

  // A kick on the expiry edge wins, so expiry requires no kick.
  assign wdog_expire = (state_q == ST_DONE) && !wdog_kick && (wcnt_q == WDOG_LAST);

  always_comb begin
    wcnt_d  = '0;
    fired_d = fired_q | wdog_expire;
    if (state_q == ST_DONE && state_d == ST_DONE && !wdog_kick)
      wcnt_d = wcnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge clearb) begin
    if (!clearb) begin
      wcnt_q  <= '0;
      fired_q <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      fired_q <= fired_d;
    end
  end

  assign wdog_fired = fired_q;
`else
  assign wdog_expire = 1'b0;
`endif

  // Soft restart is meaningless while still waiting for the synchroniser.
  assign restart = (soft_rst_req || wdog_expire) && (state_q != ST_ASSERT);

  always_ff @(posedge clock or negedge clearb) begin
    if (!clearb) begin
      state_q <= ST_ASSERT;
      hcnt_q  <= '0;
      scnt_q  <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      scnt_q  <= scnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ASSERT:  if (sync_n) state_d = ST_HOLD;
      ST_HOLD:    if (hcnt_q == HOLD_LAST)
                    state_d = (NUM_DOMAINS == 1) ? ST_DONE : ST_RELEASE;
      ST_RELEASE: if (scnt_q == STAG_LAST && idx_q == '0) state_d = ST_DONE;
      default:    state_d = ST_DONE;
    endcase
    if (restart) state_d = ST_HOLD;
  end

  always_comb begin
    hcnt_d  = hcnt_q;
    scnt_d  = scnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    case (state_q)
      ST_ASSERT: hcnt_d = '0;
      ST_HOLD: begin
        if (hcnt_q == HOLD_LAST) begin
          stage_d[NUM_DOMAINS-1] = 1'b1;
          if (NUM_DOMAINS > 1) idx_d = IDX_FIRST;
          scnt_d = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (scnt_q == STAG_LAST) begin
          stage_d[idx_q] = 1'b1;
          scnt_d = '0;
          if (idx_q != '0) idx_d = idx_q - 1'b1;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (restart) begin
      stage_d = '0;
      hcnt_d  = '0;
      scnt_d  = '0;
      idx_d   = '0;
    end
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_DONE);
  end

  assign stage_clearb = stage_q;
  assign rst_done     = done_q;
  assign busy         = busy_q;
  assign fsm_state    = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: main instance (SYNC=2, HOLD=4, N=3, STAGGER=2) and a degenerate
// instance (N=1, HOLD=1, STAGGER=1) sharing clock, clearb and soft_rst_req.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  logic         clock = 1'b0;
  logic         clearb = 1'b1;
  logic         soft_rst_req = 1'b0;
  logic [2:0]   stage_clearb;
  logic         rst_done, busy;
  reset_state_e fsm_state;
  logic [0:0]   stage1;
  logic         done1, busy1;
  reset_state_e state1;
`ifdef RESET_WDOG_EN
  logic         wdog_kick = 1'b0;
  logic         wdog_fired;
  logic         wdog_kick1 = 1'b0;
  logic         wdog_fired1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  reset_sequencer #(
    .SYNC_STAGES(2), .HOLD_CYCLES(4), .NUM_DOMAINS(3), .STAGGER(2), .WDOG_CYCLES(8)
  ) dut (
    .clock        (clock),
    .clearb       (clearb),
    .soft_rst_req (soft_rst_req),
    .stage_clearb (stage_clearb),
    .rst_done     (rst_done),
    .busy         (busy),
`ifdef RESET_WDOG_EN
    .wdog_kick    (wdog_kick),
    .wdog_fired   (wdog_fired),
`endif
    .fsm_state    (fsm_state)
  );

  reset_sequencer #(
    .SYNC_STAGES(2), .HOLD_CYCLES(1), .NUM_DOMAINS(1), .STAGGER(1), .WDOG_CYCLES(1024)
  ) dut1 (
    .clock        (clock),
    .clearb       (clearb),
    .soft_rst_req (soft_rst_req),
    .stage_clearb (stage1),
    .rst_done     (done1),
    .busy         (busy1),
`ifdef RESET_WDOG_EN
    .wdog_kick    (wdog_kick1),
    .wdog_fired   (wdog_fired1),
`endif
    .fsm_state    (state1)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, " stage"}, 32'(stage_clearb), 32'd0);
    check_val({tag, " done"},  32'(rst_done), 32'd0);
    check_val({tag, " busy"},  32'(busy), 32'd1);
    check_val({tag, " state"}, 32'(fsm_state), 32'(ST_ASSERT));
    check_val({tag, " stage1"}, 32'(stage1), 32'd0);
    check_val({tag, " busy1"},  32'(busy1), 32'd1);
  endtask

  // e counts edges from clearb release (E0); HOLD is entered at E2.
  task automatic seq_edges(input string tag, input int from, input int to, input bit chk1);
    logic [2:0]   exp_stage;
    reset_state_e exp_state;
    for (int e = from; e <= to; e++) begin
      tick();
      exp_stage = 3'b000;
      if (e >= 6)  exp_stage[2] = 1'b1;
      if (e >= 8)  exp_stage[1] = 1'b1;
      if (e >= 10) exp_stage[0] = 1'b1;
      exp_state = (e < 2) ? ST_ASSERT : (e < 6) ? ST_HOLD : (e < 10) ? ST_RELEASE : ST_DONE;
      check_val($sformatf("%s E%0d stage", tag, e), 32'(stage_clearb), 32'(exp_stage));
      check_val($sformatf("%s E%0d done", tag, e),  32'(rst_done), 32'(e >= 10));
      check_val($sformatf("%s E%0d busy", tag, e),  32'(busy), 32'(e < 10));
      check_val($sformatf("%s E%0d state", tag, e), 32'(fsm_state), 32'(exp_state));
      if (chk1) begin
        exp_state = (e < 2) ? ST_ASSERT : (e < 3) ? ST_HOLD : ST_DONE;
        check_val($sformatf("%s E%0d n1 stage", tag, e), 32'(stage1), 32'(e >= 3));
        check_val($sformatf("%s E%0d n1 done", tag, e),  32'(done1), 32'(e >= 3));
        check_val($sformatf("%s E%0d n1 state", tag, e), 32'(state1), 32'(exp_state));
      end
    end
  endtask

  initial begin
    // Power-on: produce a real falling edge on clearb.
    #2 clearb = 1'b0;
    #1 check_reset_state("por async");
    tick();
    tick();
    check_reset_state("por held");

    // Test 1: normal power-on sequence.
    clearb = 1'b1;
    seq_edges("t1", 0, 11, 1'b1);

    // Test 2: clearb pulsed mid-RELEASE clears with no clock edge.
    clearb = 1'b0;
    tick();
    clearb = 1'b1;
    seq_edges("t2a", 0, 7, 1'b1);
    clearb = 1'b0;
    #1 check_reset_state("t2 async");
    tick();
    check_reset_state("t2 held");
    clearb = 1'b1;
    seq_edges("t2b", 0, 10, 1'b1);

    // Test 3: one-cycle soft reset from DONE re-enters HOLD (equivalent to E2).
    soft_rst_req = 1'b1;
    seq_edges("t3 soft", 2, 2, 1'b1);
    soft_rst_req = 1'b0;
    seq_edges("t3", 3, 11, 1'b1);

    // Test 4: soft request while in ASSERT is ignored.
    clearb = 1'b0;
    soft_rst_req = 1'b1;
    #1 check_reset_state("t4 async");
    tick();
    tick();
    check_reset_state("t4 held");
    clearb = 1'b1;
    seq_edges("t4", 0, 1, 1'b1);
    soft_rst_req = 1'b0;
    seq_edges("t4", 2, 11, 1'b1);

`ifdef RESET_WDOG_EN
    // Test 5: DONE entered at E10, so expiry fires on E18 without kicks.
    check_val("t5 fired init", 32'(wdog_fired), 32'd0);
    for (int e = 12; e <= 17; e++) begin
      tick();
      check_val($sformatf("t5 E%0d busy", e), 32'(busy), 32'd0);
      check_val($sformatf("t5 E%0d fired", e), 32'(wdog_fired), 32'd0);
    end
    tick();
    check_val("t5 expire busy", 32'(busy), 32'd1);
    check_val("t5 expire stage", 32'(stage_clearb), 32'd0);
    check_val("t5 expire state", 32'(fsm_state), 32'(ST_HOLD));
    check_val("t5 expire fired", 32'(wdog_fired), 32'd1);
    seq_edges("t5 rerun", 3, 10, 1'b0);
    check_val("t5 fired sticky", 32'(wdog_fired), 32'd1);
    for (int i = 0; i < 20; i++) begin
      wdog_kick = (i % 4 == 0);
      tick();
      check_val($sformatf("t5 kick %0d busy", i), 32'(busy), 32'd0);
    end
    wdog_kick = 1'b0;
    clearb = 1'b0;
    #1 check_val("t5 fired cleared", 32'(wdog_fired), 32'd0);
    clearb = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
